// File: rtl/queue_ctrl_2x109.sv
// queue_ctrl_2x109: ready/valid pointer and occupancy control for a 2x109 register-file queue
module queue_ctrl_2x109 #(
  parameter int WIDTH = 109,
  parameter int ENTRIES = 2,
  parameter int FLOW = 0,
  parameter int PIPE = 0,
  localparam int AW = $clog2(ENTRIES),
  localparam int CW = $clog2(ENTRIES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             io_enq_ready,
  input  logic             io_enq_valid,
  input  logic [WIDTH-1:0] io_enq_bits,
  input  logic             io_deq_ready,
  output logic             io_deq_valid,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [CW-1:0]    io_count,
  output logic [AW-1:0]    ram_W0_addr,
  output logic             ram_W0_en,
  output logic             ram_W0_clk,
  output logic [WIDTH-1:0] ram_W0_data,
  output logic [AW-1:0]    ram_R0_addr,
  output logic             ram_R0_en,
  output logic             ram_R0_clk,
  input  logic [WIDTH-1:0] ram_R0_data
);
  logic [AW-1:0] enq_ptr, deq_ptr;
  logic          maybe_full, match, empty, full, bypass, do_enq, do_deq;
  logic [CW-1:0] e, d, diff;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction
  assign match  = enq_ptr == deq_ptr;
  assign empty  = match & ~maybe_full;
  assign full   = match & maybe_full;
  assign bypass = (FLOW != 0) & empty;
  assign io_enq_ready = ~reset & (~full | ((PIPE != 0) & io_deq_ready));
  assign io_deq_valid = ~reset & (~empty | (bypass & io_enq_valid));
  assign io_deq_bits  = bypass ? io_enq_bits : ram_R0_data;
  // an empty FLOW queue hands the payload straight through without touching the RAM
  assign do_enq = io_enq_ready & io_enq_valid & ~(bypass & io_deq_ready);
  assign do_deq = io_deq_ready & io_deq_valid & ~(bypass & io_deq_ready);
  assign e    = CW'(enq_ptr);
  assign d    = CW'(deq_ptr);
  assign diff = (e >= d) ? e - d : e + CW'(ENTRIES) - d;
  assign io_count = match ? (maybe_full ? CW'(ENTRIES) : '0) : diff;
  assign ram_W0_addr = enq_ptr;
  assign ram_W0_en   = do_enq;
  assign ram_W0_clk  = clock;
  assign ram_W0_data = io_enq_bits;
  assign ram_R0_addr = deq_ptr;
  assign ram_R0_en   = ~empty;
  assign ram_R0_clk  = clock;
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) enq_ptr <= inc(enq_ptr);
      if (do_deq) deq_ptr <= inc(deq_ptr);
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end
endmodule
